talk_sequencer: RTL

- Controller that converts one signed 8-bit calculator result into a spoken word sequence: optional "minus", then decimal digits with leading zeros suppressed.
- Drives the speech talker one word at a time using the start_talk/talk_done handshake.
- Sits between the calculator FSM result register and the talker, which is the shared speech resource.
- Contains a watchdog so that a talker which never answers cannot hang the calculator.

---
 rtl/talk_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/talk_sequencer.sv
// Speaks one signed 8-bit result as "minus" plus decimal digits,
// one word per start_talk/talk_done handshake, with a watchdog.
module talk_sequencer #(
  parameter logic [7:0] WORD_DIGIT_BASE = 8'h00,
  parameter logic [7:0] WORD_MINUS = 8'h0B,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic [7:0] req_value,
  output logic       req_ready,
  output logic       start_talk,
  output logic [7:0] word_code,
  input  logic       talk_done,
  output logic       busy,
  output logic       done,
  output logic       timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  state_t          state;
  logic [3:0][7:0] words;
  logic [1:0]      idx;
  logic [1:0]      last;
  logic [CW-1:0]   cnt;

  logic [8:0]      sx;
  logic [8:0]      mag;
  logic [8:0]      q10;
  logic [3:0]      hun;
  logic [3:0]      ten;
  logic [3:0]      one;
  logic [3:0][7:0] words_n;
  logic [2:0]      n;
  logic [1:0]      last_n;

  // sign-extend to 9 bits so -128 has a representable magnitude
  assign sx  = {req_value[7], req_value};
  assign mag = sx[8] ? (~sx + 9'd1) : sx;
  assign q10 = mag / 9'd10;
  assign hun = 4'(mag / 9'd100);
  assign ten = 4'(q10 % 9'd10);
  assign one = 4'(mag % 9'd10);

  always_comb begin
    words_n = '0;
    n = 3'd0;
    if (req_value[7]) begin
      words_n[n[1:0]] = WORD_MINUS;
      n = n + 3'd1;
    end
    if (hun != 4'd0) begin
      words_n[n[1:0]] = WORD_DIGIT_BASE + {4'd0, hun};
      n = n + 3'd1;
    end
    if (hun != 4'd0 || ten != 4'd0) begin
      words_n[n[1:0]] = WORD_DIGIT_BASE + {4'd0, ten};
      n = n + 3'd1;
    end
    words_n[n[1:0]] = WORD_DIGIT_BASE + {4'd0, one};
    n = n + 3'd1;
    last_n = 2'(n - 3'd1);
  end

  assign busy      = (state != IDLE);
  assign req_ready = (state == IDLE) && reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      start_talk  <= 1'b0;
      word_code   <= 8'h00;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      words       <= '0;
      idx         <= 2'd0;
      last        <= 2'd0;
      cnt         <= '0;
    end else begin
      start_talk  <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            words      <= words_n;
            last       <= last_n;
            idx        <= 2'd0;
            word_code  <= words_n[0];
            start_talk <= 1'b1;
            cnt        <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= cnt + 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          // talk_done has priority over the watchdog limit
          if (talk_done) begin
            if (idx == last) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              idx        <= idx + 2'd1;
              word_code  <= words[idx + 2'd1];
              start_talk <= 1'b1;
              cnt        <= '0;
              state      <= ISSUE;
            end
          end else if (cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            words       <= '0;
            idx         <= 2'd0;
            last        <= 2'd0;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
